// File: rtl/printer_arbiter.sv
// Round-robin arbiter that lends the shared printer/tx string engine to one
// requester at a time, returning a done or timeout pulse to the owner.
module printer_arbiter #(
  parameter int N_REQ       = 4,
  parameter int STR_W       = 2,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int CNT_W       = 21
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*STR_W-1:0] str_id,
  input  logic                   printer_done,
  output logic                   printer_enable,
  output logic [STR_W-1:0]       printer_str_id,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic                   busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] cnt;

  logic [STR_W-1:0] ids [N_REQ];
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             timeout_hit;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ids
      assign ids[gi] = str_id[gi*STR_W +: STR_W];
    end
  endgenerate

  // First requester found searching upward from the slot after the last winner.
  always_comb begin
    logic found;
    int   idx;
    found  = 1'b0;
    idx    = 0;
    winner = rr_ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_req     = |req;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= IDX_W'(N_REQ - 1);
      owner          <= '0;
      cnt            <= '0;
      printer_enable <= 1'b0;
      printer_str_id <= '0;
      grant          <= '0;
      done           <= '0;
      err            <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant          <= N_REQ'(1) << winner;
            printer_str_id <= ids[winner];
            printer_enable <= 1'b1;
            rr_ptr         <= winner;
            owner          <= winner;
            cnt            <= '0;
            state          <= OWN;
          end
        end
        OWN: begin
          cnt <= cnt + 1'b1;
          // A done arriving on the expiry cycle still counts as success.
          if (printer_done) begin
            printer_enable <= 1'b0;
            grant          <= '0;
            done[owner]    <= 1'b1;
            state          <= RELEASE;
          end else if (timeout_hit) begin
            printer_enable <= 1'b0;
            grant          <= '0;
            err[owner]     <= 1'b1;
            state          <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_pulse_onehot: assert property (@(posedge clk) disable iff (!rst_n)
                                   $onehot0(done) && $onehot0(err) && !((|done) && (|err)));
  a_enable_grant: assert property (@(posedge clk) disable iff (!rst_n) printer_enable == (|grant));
`endif

endmodule
